// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared types and lit-segment patterns (gfedcba, 1 = lit).
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int CODE_W = 5;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b1111100;
    localparam seg_t SEG_C     = 7'b0111001;
    localparam seg_t SEG_D     = 7'b1011110;
    localparam seg_t SEG_E     = 7'b1111001;
    localparam seg_t SEG_F     = 7'b1110001;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_if
// Brief    : Digit-code input and segment-drive output of the display block.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_if;
    import seg7_pkg::*;

    logic [CODE_W-1:0] in;
    seg_t              leds;

    modport master (output in, input  leds);
    modport slave  (input  in, output leds);

endinterface : seg7_if
`default_nettype wire

// File: rtl/seg7_lut.sv
`default_nettype none
// ============================================================================
// Module   : seg7_lut
// Brief    : Combinational map from 5-bit digit code to lit-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_lut
    import seg7_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  wire logic [CODE_W-1:0] i_code,
    output seg_t                   o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            5'd0:    o_seg = SEG_0;
            5'd1:    o_seg = SEG_1;
            5'd2:    o_seg = SEG_2;
            5'd3:    o_seg = SEG_3;
            5'd4:    o_seg = SEG_4;
            5'd5:    o_seg = SEG_5;
            5'd6:    o_seg = SEG_6;
            5'd7:    o_seg = SEG_7;
            5'd8:    o_seg = SEG_8;
            5'd9:    o_seg = SEG_9;
            5'd10:   o_seg = HEX_EN ? SEG_A : SEG_BLANK;
            5'd11:   o_seg = HEX_EN ? SEG_B : SEG_BLANK;
            5'd12:   o_seg = HEX_EN ? SEG_C : SEG_BLANK;
            5'd13:   o_seg = HEX_EN ? SEG_D : SEG_BLANK;
            5'd14:   o_seg = HEX_EN ? SEG_E : SEG_BLANK;
            5'd15:   o_seg = HEX_EN ? SEG_F : SEG_BLANK;
            // Codes 16-31 are out of the displayable range and stay dark.
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule : seg7_lut
`default_nettype wire

// File: rtl/seg7.sv
`default_nettype none
// ============================================================================
// Module   : seg7
// Brief    : Registered seven-segment decoder with selectable drive polarity.
// Revision : 1.0 - initial release
// ============================================================================
module seg7
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_EN     = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    seg7_if.slave     bus
);

    localparam seg_t c_BLANK_DRIVE = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    seg_t w_lit;
    seg_t w_drive;
    seg_t r_leds;

    seg7_lut #(
        .HEX_EN (HEX_EN)
    ) u_lut (
        .i_code (bus.in),
        .o_seg  (w_lit)
    );

    assign w_drive = ACTIVE_LOW ? ~w_lit : w_lit;

    // Async reset forces the blank drive straight onto the register output,
    // so no decoded pattern can appear while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds <= c_BLANK_DRIVE;
        end else begin
            r_leds <= w_drive;
        end
    end

    assign bus.leds = r_leds;

endmodule : seg7
`default_nettype wire

// File: tb/tb_seg7.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7
// Brief    : Self-checking bench for seg7 across three parameter builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7;

    typedef struct {
        logic [4:0] code;
        logic [6:0] al;
        logic [6:0] nh;
        logic [6:0] ah;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] tb_in = 5'd5;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vecs [19];

    // Segment letters lit for each hex digit.
    string c_letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                              "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                              "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    seg7_if u_if_al ();
    seg7_if u_if_nh ();
    seg7_if u_if_ah ();

    assign u_if_al.in = tb_in;
    assign u_if_nh.in = tb_in;
    assign u_if_ah.in = tb_in;

    seg7 #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_dut_al (.clk(clk), .reset(reset), .bus(u_if_al.slave));
    seg7 #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_dut_nh (.clk(clk), .reset(reset), .bus(u_if_nh.slave));
    seg7 #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_dut_ah (.clk(clk), .reset(reset), .bus(u_if_ah.slave));

    always #5 clk = ~clk;

    function automatic logic [6:0] model(int code, bit hex, bit al, bit rst);
        logic [6:0] lit;
        string      s;
        lit = 7'b0;
        if (!rst && (code < 10 || (code < 16 && hex))) begin
            s = c_letters[code];
            for (int i = 0; i < s.len(); i++) lit[int'(s[i]) - 97] = 1'b1;
        end
        return al ? ~lit : lit;
    endfunction

    task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk3(string tag, logic [6:0] e_al, logic [6:0] e_nh, logic [6:0] e_ah);
        chk({tag, "/al"}, u_if_al.leds, e_al);
        chk({tag, "/nh"}, u_if_nh.leds, e_nh);
        chk({tag, "/ah"}, u_if_ah.leds, e_ah);
    endtask

    initial begin
        vecs[0]  = '{5'd0,  7'b1000000, 7'b1000000, 7'b0111111};
        vecs[1]  = '{5'd1,  7'b1111001, 7'b1111001, 7'b0000110};
        vecs[2]  = '{5'd2,  7'b0100100, 7'b0100100, 7'b1011011};
        vecs[3]  = '{5'd3,  7'b0110000, 7'b0110000, 7'b1001111};
        vecs[4]  = '{5'd4,  7'b0011001, 7'b0011001, 7'b1100110};
        vecs[5]  = '{5'd5,  7'b0010010, 7'b0010010, 7'b1101101};
        vecs[6]  = '{5'd6,  7'b0000010, 7'b0000010, 7'b1111101};
        vecs[7]  = '{5'd7,  7'b1111000, 7'b1111000, 7'b0000111};
        vecs[8]  = '{5'd8,  7'b0000000, 7'b0000000, 7'b1111111};
        vecs[9]  = '{5'd9,  7'b0010000, 7'b0010000, 7'b1101111};
        vecs[10] = '{5'd10, 7'b0001000, 7'b1111111, 7'b1110111};
        vecs[11] = '{5'd11, 7'b0000011, 7'b1111111, 7'b1111100};
        vecs[12] = '{5'd12, 7'b1000110, 7'b1111111, 7'b0111001};
        vecs[13] = '{5'd13, 7'b0100001, 7'b1111111, 7'b1011110};
        vecs[14] = '{5'd14, 7'b0000110, 7'b1111111, 7'b1111001};
        vecs[15] = '{5'd15, 7'b0001110, 7'b1111111, 7'b1110001};
        vecs[16] = '{5'd16, 7'b1111111, 7'b1111111, 7'b0000000};
        vecs[17] = '{5'd31, 7'b1111111, 7'b1111111, 7'b0000000};
        vecs[18] = '{5'd0,  7'b1000000, 7'b1000000, 7'b0111111};

        // Reset with in=5 and no clock edge yet: blank must appear at once.
        #1 reset = 1'b1;
        #1 chk3("rst_async", 7'b1111111, 7'b1111111, 7'b0000000);
        repeat (2) begin
            @(posedge clk); #1;
            chk3("rst_hold", 7'b1111111, 7'b1111111, 7'b0000000);
        end

        @(negedge clk);
        reset = 1'b0;
        tb_in = vecs[0].code;
        #1 chk3("rst_release_noedge", 7'b1111111, 7'b1111111, 7'b0000000);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            tb_in = vecs[i].code;
            @(posedge clk); #1;
            chk3($sformatf("vec%0d_code%0d", i, vecs[i].code), vecs[i].al, vecs[i].nh, vecs[i].ah);
        end

        // New input must not reach leds before the next edge.
        @(negedge clk);
        tb_in = 5'd9;
        #1 chk3("no_comb_path", 7'b1000000, 7'b1000000, 7'b0111111);
        @(posedge clk); #1;
        chk3("mid_9", 7'b0010000, 7'b0010000, 7'b1101111);

        // Reset between edges blanks immediately and holds across an edge.
        #2 reset = 1'b1;
        #1 chk3("mid_rst_async", 7'b1111111, 7'b1111111, 7'b0000000);
        @(posedge clk); #1;
        chk3("mid_rst_hold", 7'b1111111, 7'b1111111, 7'b0000000);
        @(negedge clk);
        reset = 1'b0;
        tb_in = 5'd3;
        @(posedge clk); #1;
        chk3("post_rst_3", 7'b0110000, 7'b0110000, 7'b1001111);

        // Randomized codes with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            logic r_bit;
            int   code;
            @(negedge clk);
            code  = int'($urandom_range(0, 31));
            r_bit = ($urandom_range(0, 15) == 0);
            tb_in = 5'(code);
            reset = r_bit;
            @(posedge clk); #1;
            chk3($sformatf("rnd%0d_code%0d_rst%0d", i, code, r_bit),
                 model(code, 1'b1, 1'b1, r_bit),
                 model(code, 1'b0, 1'b1, r_bit),
                 model(code, 1'b1, 1'b0, r_bit));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seg7
`default_nettype wire
